fp_wb_ctrl: RTL and testbench
=============================

Name: fp_wb_ctrl

Overview:
- Response-side counterpart of the FP instruction decoder.
- Records the destination of every issued FPU operation in an in-order pending queue.
- Accepts results from the fpnew output handshake and routes each one to the FP register file or the integer register file.
- Accumulates sticky IEEE exception flags (fflags) and gives the pipeline a busy/stall view of in-flight FP work.

Parameters:
- DEPTH, 4, number of pending-op entries; power of two, minimum 2.
- FLEN, 32, FP result / FP register width.
- XLEN, 32, integer register width; results going to the integer file use result bits [XLEN-1:0].

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- issue_valid_i  in  1  decoder has an FPU op issuing this cycle (fpu_valid qualified by core accept).
- issue_ready_o  out  1  queue can accept an issue.
- issue_waddr_i  in  5  destination register index.
- issue_regwrite_i  in  1  op writes a register (0 for FSW-style ops with no writeback).
- issue_to_int_i  in  1  destination is the integer file (FEQ/FLT/FLE, FCVT.W[U].S, FMV.X.W, FCLASS).
- fpu_out_valid_i  in  1  FPU result valid.
- fpu_out_ready_o  out  1  result accepted.
- fpu_result_i  in  FLEN  FPU result.
- fpu_status_i  in  5  {NV,DZ,OF,UF,NX} for this result.
- fp_rf_we_o  out  1  FP register file write enable.
- fp_rf_waddr_o  out  5  FP register file write address.
- fp_rf_wdata_o  out  FLEN  FP register file write data.
- int_rf_we_o  out  1  integer register file write enable.
- int_rf_waddr_o  out  5  integer register file write address.
- int_rf_wdata_o  out  XLEN  integer register file write data.
- int_wb_ready_i  in  1  integer writeback port is free this cycle.
- fflags_o  out  5  sticky accumulated exception flags.
- fflags_clr_i  in  1  clear fflags (CSR write).
- busy_o  out  1  at least one op pending.
- pending_cnt_o  out  $clog2(DEPTH)+1  number of pending entries.
- protocol_err_o  out  1  sticky: result presented while queue empty.

Behaviour:
- Reset (rst_i high at posedge):
  - Queue empties; fflags, protocol_err_o and all write enables go to 0.
  - pending_cnt_o = 0, busy_o = 0; waddr/wdata outputs go to 0.
  - issue_ready_o and fpu_out_ready_o are forced 0 combinationally while rst_i is high.
  - Reset mid-operation discards all pending entries; the FPU shares this reset.
- Queue: circular FIFO of {to_int, regwrite, waddr}, 7 bits per entry.
  - Pointers carry one extra wrap bit; full when indices are equal and wrap bits differ.
  - issue_ready_o = !full. This is not pop-aware: when full, a push is refused even if a pop happens in the same cycle.
  - Push on issue_valid_i && issue_ready_o.
- Result accept: fpu_out_ready_o = !empty && (!head.to_int || int_wb_ready_i).
  - Pop on fpu_out_valid_i && fpu_out_ready_o.
  - Results are strictly in order; no tags.
- Same-cycle push and result when empty: the result is not accepted (the queue is empty that cycle). It is accepted the next cycle.
- Writeback is registered, 1-cycle latency after the pop handshake:
  - fp_rf_we_o = regwrite && !to_int; fp_rf_wdata_o = fpu_result_i. f0 writes are allowed.
  - int_rf_we_o = regwrite && to_int && (waddr != 0); int_rf_wdata_o = fpu_result_i[XLEN-1:0].
  - Write enables pulse for exactly one cycle per pop. Address and data outputs hold their last value when the enable is 0.
- fflags update per cycle:
  - Pop: next = (fflags_clr_i ? 0 : fflags) | fpu_status_i.
  - No pop: next = fflags_clr_i ? 0 : fflags.
  - Flags are accumulated even for regwrite=0 entries.
- pending_cnt_o tracks pushes minus pops (simultaneous push+pop leaves it unchanged). busy_o = (pending_cnt_o != 0). Both are registered.
- protocol_err_o is set when fpu_out_valid_i is high while the queue is empty, and cleared only by reset.
- Stalls: while int_wb_ready_i is low and the head entry is to_int, the result is held by the FPU (fpu_out_ready_o = 0) and the queue is unchanged.

Test Plan:
- Issue FADD (waddr=3, to_int=0); FPU returns 0x3F800000, status 0 two cycles later → next cycle fp_rf_we_o=1, waddr 3, wdata 0x3F800000; pending_cnt 1→0.
- Issue 4 ops back-to-back with DEPTH=4 → issue_ready_o=0 on the 5th cycle. Pop one while issuing a 5th in the same cycle → 5th refused; accepted the cycle after; pointers wrap correctly.
- Issue FEQ to x5 and FCVT.W.S to x0; int_wb_ready_i=0 for 3 cycles → fpu_out_ready_o=0 for 3 cycles. Then FEQ writes int x5 = 1; the x0 op pops with int_rf_we_o=0.
- Results with status 0x01, then 0x10; fflags_clr_i on the second pop cycle → fflags 0x01, then 0x10 (not 0x11).
- fpu_out_valid_i=1 with the queue empty → fpu_out_ready_o=0, protocol_err_o=1 and sticky; cleared by rst_i.
- rst_i asserted with 3 pending ops → next cycle pending_cnt 0, busy 0, fflags 0, no write enables; issue_ready_o=0 during reset.

Source files
------------

// File: rtl/fp_wb_ctrl.sv
// FP writeback controller: tracks issued FPU ops in an in-order pending queue,
// routes each returning result to the FP or integer register file, accumulates
// sticky IEEE exception flags and reports in-flight FP work to the pipeline.
module fp_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int FLEN  = 32,
    parameter int XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [4:0]                 issue_waddr_i,
    input  logic                       issue_regwrite_i,
    input  logic                       issue_to_int_i,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    input  logic [FLEN-1:0]            fpu_result_i,
    input  logic [4:0]                 fpu_status_i,
    output logic                       fp_rf_we_o,
    output logic [4:0]                 fp_rf_waddr_o,
    output logic [FLEN-1:0]            fp_rf_wdata_o,
    output logic                       int_rf_we_o,
    output logic [4:0]                 int_rf_waddr_o,
    output logic [XLEN-1:0]            int_rf_wdata_o,
    input  logic                       int_wb_ready_i,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     pending_cnt_o,
    output logic                       protocol_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic       to_int;
        logic       regwrite;
        logic [4:0] waddr;
    } entry_t;

    entry_t          mem_r [DEPTH];
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic [4:0]      fflags_r;
    logic            perr_r;
    logic            fp_we_r;
    logic [4:0]      fp_waddr_r;
    logic [FLEN-1:0] fp_wdata_r;
    logic            int_we_r;
    logic [4:0]      int_waddr_r;
    logic [XLEN-1:0] int_wdata_r;

    entry_t          head_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   cnt_next_s;
    logic [4:0]      fflags_next_s;

    // Queue status, handshakes and next-state values for counters and flags.
    always_comb begin
        head_s        = mem_r[rd_ptr_r[AW-1:0]];
        full_s        = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        empty_s       = (wr_ptr_r == rd_ptr_r);
        issue_ready_o = !rst_i && !full_s;
        fpu_out_ready_o = !rst_i && !empty_s && (!head_s.to_int || int_wb_ready_i);
        push_s        = issue_valid_i && issue_ready_o;
        pop_s         = fpu_out_valid_i && fpu_out_ready_o;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + CNT_ONE;
            2'b01:   cnt_next_s = cnt_r - CNT_ONE;
            default: cnt_next_s = cnt_r;
        endcase
        if (fflags_clr_i) begin
            fflags_next_s = 5'b00000;
        end else begin
            fflags_next_s = fflags_r;
        end
        if (pop_s) begin
            fflags_next_s = fflags_next_s | fpu_status_i;
        end else begin
            fflags_next_s = fflags_next_s;
        end
    end

    // Pending queue storage, pointers, occupancy, sticky flags and error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            fflags_r <= 5'b00000;
            perr_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= '{to_int: issue_to_int_i,
                                             regwrite: issue_regwrite_i,
                                             waddr: issue_waddr_i};
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r    <= cnt_next_s;
            busy_r   <= (cnt_next_s != '0);
            fflags_r <= fflags_next_s;
            if (fpu_out_valid_i && empty_s) begin
                perr_r <= 1'b1;
            end
        end
    end

    // Registered writeback to the FP and integer register files; x0 is never written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fp_we_r     <= 1'b0;
            fp_waddr_r  <= 5'b00000;
            fp_wdata_r  <= '0;
            int_we_r    <= 1'b0;
            int_waddr_r <= 5'b00000;
            int_wdata_r <= '0;
        end else begin
            fp_we_r  <= pop_s && head_s.regwrite && !head_s.to_int;
            int_we_r <= pop_s && head_s.regwrite && head_s.to_int && (head_s.waddr != 5'b00000);
            if (pop_s && head_s.regwrite && !head_s.to_int) begin
                fp_waddr_r <= head_s.waddr;
                fp_wdata_r <= fpu_result_i;
            end
            if (pop_s && head_s.regwrite && head_s.to_int && (head_s.waddr != 5'b00000)) begin
                int_waddr_r <= head_s.waddr;
                int_wdata_r <= fpu_result_i[XLEN-1:0];
            end
        end
    end

    assign fp_rf_we_o     = fp_we_r;
    assign fp_rf_waddr_o  = fp_waddr_r;
    assign fp_rf_wdata_o  = fp_wdata_r;
    assign int_rf_we_o    = int_we_r;
    assign int_rf_waddr_o = int_waddr_r;
    assign int_rf_wdata_o = int_wdata_r;
    assign fflags_o       = fflags_r;
    assign busy_o         = busy_r;
    assign pending_cnt_o  = cnt_r;
    assign protocol_err_o = perr_r;

endmodule

// File: tb/tb_fp_wb_ctrl.sv
// Scoreboard bench for fp_wb_ctrl: a queue-based reference model predicts
// handshakes, occupancy and flags; expected writebacks are queued and checked
// by an independent monitor whenever the DUT raises a write enable.
module tb_fp_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  issue_waddr_i;
    logic        issue_regwrite_i;
    logic        issue_to_int_i;
    logic        fpu_out_valid_i;
    logic        fpu_out_ready_o;
    logic [31:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic        fp_rf_we_o;
    logic [4:0]  fp_rf_waddr_o;
    logic [31:0] fp_rf_wdata_o;
    logic        int_rf_we_o;
    logic [4:0]  int_rf_waddr_o;
    logic [31:0] int_rf_wdata_o;
    logic        int_wb_ready_i;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic        busy_o;
    logic [2:0]  pending_cnt_o;
    logic        protocol_err_o;

    fp_wb_ctrl #(.DEPTH(DEPTH), .FLEN(32), .XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_waddr_i(issue_waddr_i), .issue_regwrite_i(issue_regwrite_i),
        .issue_to_int_i(issue_to_int_i),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .fp_rf_we_o(fp_rf_we_o), .fp_rf_waddr_o(fp_rf_waddr_o), .fp_rf_wdata_o(fp_rf_wdata_o),
        .int_rf_we_o(int_rf_we_o), .int_rf_waddr_o(int_rf_waddr_o), .int_rf_wdata_o(int_rf_wdata_o),
        .int_wb_ready_i(int_wb_ready_i),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .busy_o(busy_o), .pending_cnt_o(pending_cnt_o), .protocol_err_o(protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       to_int;
        bit       rw;
        bit [4:0] a;
    } pend_t;

    typedef struct {
        bit        is_int;
        bit [4:0]  a;
        bit [31:0] d;
    } wb_t;

    pend_t     mq[$];
    wb_t       wq[$];
    bit [4:0]  m_flags;
    bit        m_perr;
    int        n_cmp = 0;
    int        n_err = 0;
    wb_t       mon_w;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic set_in(bit iv, bit [4:0] a, bit rw, bit ti, bit ov,
                          bit [31:0] res, bit [4:0] st, bit iwr, bit clr);
        issue_valid_i    = iv;
        issue_waddr_i    = a;
        issue_regwrite_i = rw;
        issue_to_int_i   = ti;
        fpu_out_valid_i  = ov;
        fpu_result_i     = res;
        fpu_status_i     = st;
        int_wb_ready_i   = iwr;
        fflags_clr_i     = clr;
    endtask

    // One clock of reference model: check handshakes, advance model, check state.
    task automatic step();
        bit    e_ir, e_or, push, pop;
        pend_t h;
        wb_t   w;
        #2;
        e_ir = !rst_i && (mq.size() < DEPTH);
        e_or = 1'b0;
        if (!rst_i && mq.size() > 0) e_or = !mq[0].to_int || int_wb_ready_i;
        chk("issue_ready", issue_ready_o, e_ir);
        chk("fpu_out_ready", fpu_out_ready_o, e_or);
        push = issue_valid_i && e_ir;
        pop  = fpu_out_valid_i && e_or;
        if (rst_i) begin
            mq.delete();
            m_flags = 5'd0;
            m_perr  = 1'b0;
        end else begin
            if (fpu_out_valid_i && mq.size() == 0) m_perr = 1'b1;
            if (fflags_clr_i) m_flags = 5'd0;
            if (pop) begin
                h = mq.pop_front();
                m_flags = m_flags | fpu_status_i;
                if (h.rw && !h.to_int) begin
                    w.is_int = 1'b0; w.a = h.a; w.d = fpu_result_i; wq.push_back(w);
                end else if (h.rw && h.to_int && h.a != 5'd0) begin
                    w.is_int = 1'b1; w.a = h.a; w.d = fpu_result_i; wq.push_back(w);
                end
            end
            if (push) begin
                h.to_int = issue_to_int_i; h.rw = issue_regwrite_i; h.a = issue_waddr_i;
                mq.push_back(h);
            end
        end
        @(posedge clk);
        #1;
        chk("pending_cnt", {29'd0, pending_cnt_o}, mq.size());
        chk("busy", busy_o, mq.size() != 0);
        chk("fflags", fflags_o, m_flags);
        chk("protocol_err", protocol_err_o, m_perr);
        @(negedge clk);
    endtask

    // Writeback monitor: every write enable must match the oldest expected write.
    always @(negedge clk) begin
        if (fp_rf_we_o === 1'b1 || int_rf_we_o === 1'b1) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got fp_we=%0b int_we=%0b expected none at %0t",
                         fp_rf_we_o, int_rf_we_o, $time);
            end else begin
                mon_w = wq.pop_front();
                chk("wb_fp_we", fp_rf_we_o, !mon_w.is_int);
                chk("wb_int_we", int_rf_we_o, mon_w.is_int);
                if (mon_w.is_int) begin
                    chk("wb_int_waddr", int_rf_waddr_o, mon_w.a);
                    chk("wb_int_wdata", int_rf_wdata_o, mon_w.d);
                end else begin
                    chk("wb_fp_waddr", fp_rf_waddr_o, mon_w.a);
                    chk("wb_fp_wdata", fp_rf_wdata_o, mon_w.d);
                end
            end
        end else if (wq.size() != 0) begin
            mon_w = wq.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_write: got no write enable expected write to %0d at %0t",
                     mon_w.a, $time);
        end
    end

    initial begin
        m_flags = 5'd0;
        m_perr  = 1'b0;
        rst_i   = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        step();
        step();
        chk("rst_fp_waddr", fp_rf_waddr_o, 32'd0);
        chk("rst_int_wdata", int_rf_wdata_o, 32'd0);
        rst_i = 1'b0;

        // FADD f3, result two cycles later
        set_in(1, 5'd3, 1, 0, 0, 0, 0, 1, 0); step();
        chk("fadd_cnt1", {29'd0, pending_cnt_o}, 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); step();
        set_in(0, 0, 0, 0, 1, 32'h3F80_0000, 0, 1, 0); step();
        chk("fadd_we", fp_rf_we_o, 32'd1);
        chk("fadd_waddr", fp_rf_waddr_o, 32'd3);
        chk("fadd_wdata", fp_rf_wdata_o, 32'h3F80_0000);
        chk("fadd_cnt0", {29'd0, pending_cnt_o}, 32'd0);

        // Fill the queue, then push while popping: push is refused when full
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 5'(10 + i), 1, 0, 0, 0, 0, 1, 0); step();
        end
        set_in(1, 5'd20, 1, 0, 1, 32'hA5A5_0001, 0, 1, 0); step();
        chk("full_refused_cnt", {29'd0, pending_cnt_o}, 32'd3);
        set_in(1, 5'd20, 1, 0, 0, 0, 0, 1, 0); step();
        chk("retry_cnt", {29'd0, pending_cnt_o}, 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 0, 0, 1, 32'hB000_0000 + 32'(i), 0, 1, 0); step();
        end

        // Integer destinations with writeback port stalled
        set_in(1, 5'd5, 1, 1, 0, 0, 0, 1, 0); step();
        set_in(1, 5'd0, 1, 1, 0, 0, 0, 1, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 1, 32'd1, 0, 0, 0); step();
        end
        set_in(0, 0, 0, 0, 1, 32'd1, 0, 1, 0); step();
        chk("feq_int_we", int_rf_we_o, 32'd1);
        chk("feq_int_data", int_rf_wdata_o, 32'd1);
        set_in(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0); step();
        chk("x0_no_we", int_rf_we_o, 32'd0);

        // Flag accumulation and clear on a pop cycle
        set_in(1, 5'd1, 0, 0, 0, 0, 0, 1, 1); step();
        set_in(1, 5'd2, 0, 0, 0, 0, 0, 1, 0); step();
        set_in(0, 0, 0, 0, 1, 0, 5'h01, 1, 0); step();
        chk("fflags_first", fflags_o, 32'h01);
        set_in(0, 0, 0, 0, 1, 0, 5'h10, 1, 1); step();
        chk("fflags_clr_pop", fflags_o, 32'h10);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                   $urandom_range(0, 4) != 0, $urandom_range(0, 1),
                   (mq.size() > 0) && ($urandom_range(0, 1) == 1),
                   $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            step();
        end
        for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++) begin
            set_in(0, 0, 0, 0, 1, $urandom, 0, 1, 0); step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();

        // Result with empty queue
        set_in(0, 0, 0, 0, 1, 32'h1234_5678, 5'h1F, 1, 0); step();
        chk("perr_set", protocol_err_o, 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); step();
        chk("perr_sticky", protocol_err_o, 32'd1);

        // Reset with ops pending
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5'(7 + i), 1, 0, 0, 0, 0, 1, 0); step();
        end
        rst_i = 1'b1;
        set_in(1, 5'd9, 1, 0, 1, 32'hDEAD_BEEF, 5'h1F, 1, 0); step();
        chk("rst_cnt", {29'd0, pending_cnt_o}, 32'd0);
        chk("rst_perr", protocol_err_o, 32'd0);
        chk("rst_we", {30'd0, fp_rf_we_o, int_rf_we_o}, 32'd0);
        rst_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); step();

        n_cmp++;
        if (wq.size() != 0) begin
            n_err++;
            $display("FAIL wb_queue_drained: got %0d outstanding expected 0", wq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
